multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Parametrised multi-cycle sequencer for the 16-bit core.
//  - Decodes the instruction word and drives register-file, ALU, data-memory and PC control strobes.
//  - Adds conditional/unconditional branches, a ready/ack memory handshake with timeout, and illegal-opcode trapping.
//  - Sits between instructionMemory and the datapath; the datapath muxes and latches per this block's selects.
// PARAMETERS
//  PC_W        8   PC/branch-target width; <=10; target = instr[PC_W-1:0]
//  MEM_AW      7   data-memory address width; <=7 (fixed by encoding)
//  MEM_TIMEOUT 15  max cycles waiting for mem_ack before fault; >=1
// PORTS
//  clk          in   1        core clock, all state on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  instr        in   16       current instruction (combinational imem)
//  alu_sreg     in   4        ALU flags {V,N,C,Z} for current fsl
//  mem_ack      in   1        data memory completed rd/wr this cycle
//  ra_num       out  3        GPR read port A select
//  rb_num       out  3        GPR read port B select
//  rc_num       out  3        GPR write select
//  reg_rd_en    out  1        GPR read strobe
//  reg_wr_en    out  1        GPR write strobe (one cycle)
//  wr_sel       out  2        write source: 0 ALU, 1 imm instr[9:3], 2 port A, 3 mem latch
//  alu_fsl      out  4        ALU function select
//  alu_lat      out  1        datapath latches operands/results
//  mem_addr     out  MEM_AW   data-memory address
//  mem_rd       out  1        read request, held until ack
//  mem_wr       out  1        write request, held until ack
//  wdata_sel    out  1        mem write data: 0 port A, 1 mem latch
//  pc_hold      out  1        freeze PC
//  pc_jump      out  1        load pc_target on next PC update
//  pc_target    out  PC_W     branch target
//  sreg         out  4        architectural flags {V,N,C,Z}
//  fault        out  1        one-cycle pulse: illegal opcode or mem timeout
// BEHAVIOUR
//  Reset: state=DECODE; every output 0, sreg=0, timer=0. Reset mid-instruction aborts with no write.
//  Class = instr[15:14]. DECODE always asserts pc_hold except in DONE, the only cycle PC advances.
//  ALU 00: DECODE->RD(rd_en)->EXE(alu_lat)->WB(wr_en, wr_sel=0)->FLAG(sreg<=alu_sreg)->DONE.
//    6 cycles. ra=[9:7], rb=[6:4], rc=[3:1], fsl=[13:10].
//  LD-imm 0101: DECODE->WB(sel1)->DONE.
//  MOVR 0110: ->RD->WB(sel2)->DONE. rc=[9:7], ra=[6:4].
//  LD-ind 0100..0111 per sub: 01_0100: RD(rb=[9:7])->MREQ(addr=rb data)->MWAIT->WB(sel3)->DONE.
//  ST 01_1000: addr=[9:3], ra=[2:0]; RD->MREQ(mem_wr)->MWAIT->DONE.
//  MOV 11: addr=[13:7] rd->MWAIT->addr=[6:0] wr (wdata_sel=1)->MWAIT->DONE.
//  mem_rd/mem_wr held high from MREQ until the cycle mem_ack=1; dropped the next cycle.
//  mem_ack in the same cycle as the request is legal (zero wait).
//  Timer counts MWAIT cycles; at MEM_TIMEOUT without ack: drop request, fault pulse, no reg write, ->DONE.
//  BR 10: cond=[13:10]; [13]=1 always; else flag=sreg[[11:10]], taken if flag^[12].
//    DECODE->BR->DONE; pc_jump=taken in DONE, pc_target=instr[PC_W-1:0]. sreg unchanged.
//  Other 01 subops: fault pulse in DECODE->DONE (treated as NOP, 2 cycles).
//  pc_target to PC_W-1 wraps naturally; branch to self is legal (infinite loop).
//  Flags change only in ALU FLAG state; loads/stores/branches preserve sreg.
// STRUCTURE
//  Package cu_pkg: class codes, load subop codes, state enum, SREG bit indices Z=0 C=1 N=2 V=3, wr_sel codes.
//  Sub-module cu_mem_timer: request/ack tracker and timeout counter (start, ack, expire).
//  Main FSM is one registered state plus registered outputs; no latches.
// TESTING
//  ALU ADD r1,r2->r3, flags Z=1 -> wr_en once at cycle 4, sreg=4'b0001 at 5, PC+1 at 6.
//  LD-imm 0x55 into r6 -> wr_sel=1, rc=6, 3 cycles total, sreg unchanged.
//  ST r2 to addr 0x12, mem_ack after 3 cycles -> mem_wr high exactly 4 cycles, then DONE.
//  ST with mem_ack never -> fault at 15th wait cycle, mem_wr drops, PC advances.
//  BR cond Z=1 (0b0000 w/ [13]=0, [12]=0) with sreg.Z=1 -> pc_jump, target 0x40; Z=0 -> PC+1.
//  rst_n low during MWAIT of MOV -> all outputs 0 immediately; no mem_wr after release.

Source files
------------

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings, state enum and branch-condition helper for the multicycle control unit
package cu_pkg;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDST = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;
    localparam logic [1:0] CLS_MOV  = 2'b11;

    localparam logic [3:0] SUB_LDIND = 4'b0100;
    localparam logic [3:0] SUB_LDIMM = 4'b0101;
    localparam logic [3:0] SUB_MOVR  = 4'b0110;
    localparam logic [3:0] SUB_ST    = 4'b1000;

    localparam int SREG_Z = 0;
    localparam int SREG_C = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    localparam logic [1:0] WR_ALU   = 2'd0;
    localparam logic [1:0] WR_IMM   = 2'd1;
    localparam logic [1:0] WR_PORTA = 2'd2;
    localparam logic [1:0] WR_MEM   = 2'd3;

    typedef enum logic [3:0] {
        S_DECODE,
        S_RD,
        S_EXE,
        S_WB,
        S_FLAG,
        S_MREQ,
        S_MWAIT,
        S_BR,
        S_DONE
    } cu_state_t;

    // cond[3] forces the branch; otherwise cond[1:0] picks a flag and cond[2] inverts the test
    function automatic logic br_taken(input logic [3:0] cond, input logic [3:0] flags);
        logic flag;
        case (cond[1:0])
            2'd0:    flag = flags[SREG_Z];
            2'd1:    flag = flags[SREG_C];
            2'd2:    flag = flags[SREG_N];
            default: flag = flags[SREG_V];
        endcase
        return cond[3] | (flag ^ cond[2]);
    endfunction

endpackage

// File: rtl/cu_mem_timer.sv
// rtl/cu_mem_timer.sv - counts data-memory wait cycles and flags a timeout when no ack arrives
module cu_mem_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic wait_en,
    input  logic mem_ack,
    output logic expire
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    // count holds the number of completed wait cycles, so the last allowed one sees LAST
    assign expire = wait_en && !mem_ack && (wait_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= '0;
        end else if (wait_en && !expire) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle sequencer driving regfile, ALU, data memory and PC strobes
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int MEM_AW      = 7,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic [3:0]        alu_sreg,
    input  logic              mem_ack,
    output logic [2:0]        ra_num,
    output logic [2:0]        rb_num,
    output logic [2:0]        rc_num,
    output logic              reg_rd_en,
    output logic              reg_wr_en,
    output logic [1:0]        wr_sel,
    output logic [3:0]        alu_fsl,
    output logic              alu_lat,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              wdata_sel,
    output logic              pc_hold,
    output logic              pc_jump,
    output logic [PC_W-1:0]   pc_target,
    output logic [3:0]        sreg,
    output logic              fault
);

    cu_state_t  state_q, state_d;
    logic       mov_wr_q;
    logic [3:0] sreg_q;
    logic       expire;

    logic [1:0] cls;
    logic [3:0] sub;
    logic       is_ldind, is_ldimm, is_movr, is_st, is_illegal, is_mov, mem_read;

    assign cls        = instr[15:14];
    assign sub        = instr[13:10];
    assign is_ldind   = (cls == CLS_LDST) && (sub == SUB_LDIND);
    assign is_ldimm   = (cls == CLS_LDST) && (sub == SUB_LDIMM);
    assign is_movr    = (cls == CLS_LDST) && (sub == SUB_MOVR);
    assign is_st      = (cls == CLS_LDST) && (sub == SUB_ST);
    assign is_illegal = (cls == CLS_LDST) && !(is_ldind || is_ldimm || is_movr || is_st);
    assign is_mov     = (cls == CLS_MOV);
    assign mem_read   = is_ldind || (is_mov && !mov_wr_q);
    assign sreg       = sreg_q;

    cu_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state_q == S_MREQ),
        .wait_en (state_q == S_MWAIT),
        .mem_ack (mem_ack),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_DECODE;
            mov_wr_q <= 1'b0;
            sreg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WB && cls == CLS_ALU) begin
                sreg_q <= alu_sreg;
            end
            if (state_q == S_DONE) begin
                mov_wr_q <= 1'b0;
            end else if (is_mov && mem_ack && (state_q == S_MREQ || state_q == S_MWAIT)) begin
                mov_wr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_num    = '0;
        rb_num    = '0;
        rc_num    = '0;
        reg_rd_en = 1'b0;
        reg_wr_en = 1'b0;
        wr_sel    = WR_ALU;
        alu_fsl   = '0;
        alu_lat   = 1'b0;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        wdata_sel = 1'b0;
        pc_hold   = 1'b0;
        pc_jump   = 1'b0;
        pc_target = '0;
        fault     = 1'b0;

        unique case (state_q)
            S_DECODE: begin
                case (cls)
                    CLS_ALU:  state_d = S_RD;
                    CLS_BR:   state_d = S_BR;
                    CLS_MOV:  state_d = S_MREQ;
                    default:  state_d = is_ldimm ? S_WB : (is_illegal ? S_DONE : S_RD);
                endcase
            end
            S_RD:    state_d = (cls == CLS_ALU) ? S_EXE : (is_movr ? S_WB : S_MREQ);
            S_EXE:   state_d = S_WB;
            S_WB:    state_d = (cls == CLS_ALU) ? S_FLAG : S_DONE;
            S_FLAG:  state_d = S_DONE;
            S_MREQ, S_MWAIT: begin
                if (mem_ack) begin
                    state_d = is_ldind ? S_WB : ((is_mov && !mov_wr_q) ? S_MREQ : S_DONE);
                end else if (expire) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MWAIT;
                end
            end
            S_BR:    state_d = S_DONE;
            S_DONE:  state_d = S_DECODE;
            default: state_d = S_DECODE;
        endcase

        // outputs are forced low for the whole time reset is asserted, not just from the next edge
        if (rst_n) begin
            pc_hold = (state_q != S_DONE);

            if (cls == CLS_ALU) begin
                ra_num  = instr[9:7];
                rb_num  = instr[6:4];
                rc_num  = instr[3:1];
                alu_fsl = instr[13:10];
            end else if (is_movr) begin
                rc_num = instr[9:7];
                ra_num = instr[6:4];
            end else if (is_ldind) begin
                rb_num = instr[9:7];
                rc_num = instr[2:0];
            end else if (is_st) begin
                ra_num = instr[2:0];
            end else if (is_ldimm) begin
                rc_num = instr[2:0];
            end else if (cls == CLS_BR) begin
                pc_target = instr[PC_W-1:0];
            end

            case (state_q)
                S_DECODE: fault = is_illegal;
                S_RD:     reg_rd_en = 1'b1;
                S_EXE:    alu_lat = 1'b1;
                S_WB: begin
                    reg_wr_en = 1'b1;
                    wr_sel    = (cls == CLS_ALU) ? WR_ALU :
                                is_ldimm ? WR_IMM : (is_movr ? WR_PORTA : WR_MEM);
                end
                S_MREQ, S_MWAIT: begin
                    mem_rd    = mem_read;
                    mem_wr    = !mem_read;
                    wdata_sel = is_mov && mov_wr_q;
                    fault     = expire;
                    // indirect loads take their address from port B in the datapath
                    if (is_st) begin
                        mem_addr = instr[3 +: MEM_AW];
                    end else if (is_mov) begin
                        mem_addr = mov_wr_q ? instr[0 +: MEM_AW] : instr[7 +: MEM_AW];
                    end
                end
                S_DONE:   pc_jump = (cls == CLS_BR) && br_taken(instr[13:10], sreg_q);
                default: ;
            endcase
        end
    end

endmodule
